game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 TIMEOUT, 50, answer window length in tick_100ms pulses (5 s); legal range 1..63.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 tick_100ms  input  1  one-cycle pulse every 100 ms, synchronous to clk.
REQ-005 start  input  1  one-cycle pulse, debounced start/continue button.
REQ-006 cfg_count  input  3  requested player count from switches.
REQ-007 cfg_target  input  7  requested winning score from switches.
REQ-008 buzz  input  4  per-player buzz request, bit0 = player 1; level, sampled every cycle.
REQ-009 judge_ok  input  1  one-cycle pulse, answer correct.
REQ-010 judge_bad  input  1  one-cycle pulse, answer wrong.
REQ-011 view  output  3  0 = setup, 1 = play, 2 = win; drives view-selection inputs of the display views.
REQ-012 player_count  output  3  latched player count, 2..4.
REQ-013 player1_score..player4_score  output  7 each  binary scores, 0..99.
REQ-014 winner  output  3  winning player 1..4, 0 = none.
REQ-015 answering  output  3  player currently holding the answer slot 1..4, 0 = none.
REQ-016 time_left  output  6  remaining answer-window ticks, 0 outside ANSWER.

Function
REQ-017 FSM states SHALL be SETUP, READY, ANSWER, WIN; view = 0 in SETUP, 1 in READY/ANSWER, 2 in WIN.
REQ-018 SETUP + start: latch player_count = cfg_count clamped to 2..4 and target = cfg_target clamped to 1..99, clear all scores and winner, go READY on the same edge.
REQ-019 READY: if any buzz bit with index < player_count is set, go ANSWER, answering = lowest such index + 1, time_left = TIMEOUT; buzz bits of unused players SHALL be ignored.
REQ-020 Simultaneous buzzes SHALL be resolved by fixed priority, player 1 highest.
REQ-021 ANSWER: buzz changes SHALL be ignored; time_left decrements by 1 on each tick_100ms.
REQ-022 ANSWER + judge_ok (judge_bad low): answerer score +1, saturating at 99, visible the cycle after the pulse; if new score >= target go WIN with winner = answerer, else go READY.
REQ-023 ANSWER + judge_bad (judge_ok low), or tick_100ms while time_left == 1: answerer score -1, saturating at 0, go READY.
REQ-024 judge_ok and judge_bad asserted in the same cycle SHALL both be ignored.
REQ-025 A judge pulse SHALL take precedence over a timeout expiring in the same cycle.
REQ-026 On leaving ANSWER: answering = 0, time_left = 0.
REQ-027 WIN: all scores and winner held; start returns to SETUP (scores kept until next start in SETUP).
REQ-028 start in READY or ANSWER, and judge pulses outside ANSWER, SHALL be ignored.
REQ-029 Scores of players with index >= player_count SHALL remain 0.
REQ-030 At most one score SHALL change per cycle.

Reset
REQ-031 rst low SHALL immediately force SETUP, view = 0, player_count = 2, all scores 0, winner = 0, answering = 0, time_left = 0, target = 1, regardless of state.
REQ-032 Reset mid-ANSWER SHALL discard the pending judgement; first edge after rst release evaluates SETUP.

Verification
REQ-033 rst low, then start with cfg_count = 3, cfg_target = 2 -> view 1, player_count 3, all scores 0.
REQ-034 In READY, buzz = 4'b0110 in one cycle -> answering 2, time_left 50; judge_ok -> player2_score 1, view 1, answering 0.
REQ-035 player_count 3, buzz = 4'b1000 -> no response; then buzz = 4'b1001 -> answering 1.
REQ-036 Answer open, 50 ticks with no judge -> answerer score unchanged at 0 (saturation), answering 0; with score 1 -> score 0.
REQ-037 Target 2, player 3 at 1, judge_ok -> score 2, view 2, winner 3; start -> view 0; start -> scores cleared, view 1.
REQ-038 judge_ok and judge_bad same cycle -> no score change, state stays ANSWER; rst pulse during ANSWER -> view 0, all outputs at reset values.

Source files
------------

// File: rtl/game_ctrl.sv
// Quiz-game controller: setup, buzz arbitration, answer window, scoring.
// Four-player score board with fixed-priority buzz-in and a timed answer slot.
module game_ctrl #(
  parameter int unsigned TIMEOUT = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_100ms,
  input  logic       start,
  input  logic [2:0] cfg_count,
  input  logic [6:0] cfg_target,
  input  logic [3:0] buzz,
  input  logic       judge_ok,
  input  logic       judge_bad,
  output logic [2:0] view,
  output logic [2:0] player_count,
  output logic [6:0] player1_score,
  output logic [6:0] player2_score,
  output logic [6:0] player3_score,
  output logic [6:0] player4_score,
  output logic [2:0] winner,
  output logic [2:0] answering,
  output logic [5:0] time_left
);

  typedef enum logic [1:0] {
    SETUP,
    READY,
    ANSWER,
    WIN
  } state_t;

  localparam logic [5:0] TO = 6'(TIMEOUT);

  state_t     state_q, state_d;
  logic [2:0] pc_q, pc_d;
  logic [6:0] tgt_q, tgt_d;
  logic [6:0] sc_q [4];
  logic [6:0] sc_d [4];
  logic [2:0] win_q, win_d;
  logic [2:0] ans_q, ans_d;
  logic [5:0] tl_q, tl_d;

  logic [3:0] en;
  logic [3:0] req;
  logic [1:0] idx;
  logic [6:0] cur;
  logic [6:0] inc;
  logic [6:0] dec;
  logic       ok;
  logic       bad;
  logic       expire;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      en[i] = (3'(i) < pc_q);
    end
    req    = buzz & en;
    idx    = ans_q[1:0] - 2'd1;
    cur    = sc_q[idx];
    inc    = (cur >= 7'd99) ? 7'd99 : cur + 7'd1;
    dec    = (cur == 7'd0) ? 7'd0 : cur - 7'd1;
    ok     = judge_ok & ~judge_bad;
    bad    = judge_bad & ~judge_ok;
    expire = tick_100ms & (tl_q == 6'd1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SETUP;
      pc_q    <= 3'd2;
      tgt_q   <= 7'd1;
      win_q   <= 3'd0;
      ans_q   <= 3'd0;
      tl_q    <= 6'd0;
      for (int i = 0; i < 4; i++) sc_q[i] <= 7'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      win_q   <= win_d;
      ans_q   <= ans_d;
      tl_q    <= tl_d;
      for (int i = 0; i < 4; i++) sc_q[i] <= sc_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    win_d   = win_q;
    ans_d   = ans_q;
    tl_d    = tl_q;
    for (int i = 0; i < 4; i++) sc_d[i] = sc_q[i];
    unique case (state_q)
      SETUP: begin
        if (start) begin
          if (cfg_count < 3'd2)      pc_d = 3'd2;
          else if (cfg_count > 3'd4) pc_d = 3'd4;
          else                       pc_d = cfg_count;
          if (cfg_target == 7'd0)      tgt_d = 7'd1;
          else if (cfg_target > 7'd99) tgt_d = 7'd99;
          else                         tgt_d = cfg_target;
          for (int i = 0; i < 4; i++) sc_d[i] = 7'd0;
          win_d   = 3'd0;
          state_d = READY;
        end
      end
      READY: begin
        // Fixed priority: player 1 wins simultaneous buzzes.
        if (req != 4'd0) begin
          if (req[0])      ans_d = 3'd1;
          else if (req[1]) ans_d = 3'd2;
          else if (req[2]) ans_d = 3'd3;
          else             ans_d = 3'd4;
          tl_d    = TO;
          state_d = ANSWER;
        end
      end
      ANSWER: begin
        if (ok) begin
          sc_d[idx] = inc;
          ans_d     = 3'd0;
          tl_d      = 6'd0;
          if (inc >= tgt_q) begin
            win_d   = ans_q;
            state_d = WIN;
          end else begin
            state_d = READY;
          end
        end else if (bad || expire) begin
          sc_d[idx] = dec;
          ans_d     = 3'd0;
          tl_d      = 6'd0;
          state_d   = READY;
        end else if (tick_100ms) begin
          tl_d = tl_q - 6'd1;
        end
      end
      WIN: begin
        if (start) state_d = SETUP;
      end
      default: state_d = SETUP;
    endcase
  end

  always_comb begin
    unique case (state_q)
      SETUP:   view = 3'd0;
      WIN:     view = 3'd2;
      default: view = 3'd1;
    endcase
  end

  assign player_count  = pc_q;
  assign player1_score = sc_q[0];
  assign player2_score = sc_q[1];
  assign player3_score = sc_q[2];
  assign player4_score = sc_q[3];
  assign winner        = win_q;
  assign answering     = ans_q;
  assign time_left     = tl_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with immediate-assertion checks.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_100ms = 1'b0;
  logic       start = 1'b0;
  logic [2:0] cfg_count = 3'd0;
  logic [6:0] cfg_target = 7'd0;
  logic [3:0] buzz = 4'd0;
  logic       judge_ok = 1'b0;
  logic       judge_bad = 1'b0;
  logic [2:0] view;
  logic [2:0] player_count;
  logic [6:0] p1, p2, p3, p4;
  logic [2:0] winner;
  logic [2:0] answering;
  logic [5:0] time_left;

  int passed = 0;
  int total  = 0;

  game_ctrl #(.TIMEOUT(50)) dut (
    .clk(clk),
    .rst(rst),
    .tick_100ms(tick_100ms),
    .start(start),
    .cfg_count(cfg_count),
    .cfg_target(cfg_target),
    .buzz(buzz),
    .judge_ok(judge_ok),
    .judge_bad(judge_bad),
    .view(view),
    .player_count(player_count),
    .player1_score(p1),
    .player2_score(p2),
    .player3_score(p3),
    .player4_score(p4),
    .winner(winner),
    .answering(answering),
    .time_left(time_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_ok();
    judge_ok = 1'b1;
    cyc();
    judge_ok = 1'b0;
  endtask

  task automatic do_buzz(input logic [3:0] b);
    buzz = b;
    cyc();
    buzz = 4'd0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_100ms = 1'b1;
      cyc();
      tick_100ms = 1'b0;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_view"}, 32'(view), 0);
    chk({tag, "_pc"}, 32'(player_count), 2);
    chk({tag, "_scores"}, 32'({p1, p2, p3, p4}), 0);
    chk({tag, "_winner"}, 32'(winner), 0);
    chk({tag, "_ans"}, 32'(answering), 0);
    chk({tag, "_tl"}, 32'(time_left), 0);
  endtask

  initial begin
    #12;
    chk_reset("rst");
    cyc();
    rst = 1'b1;
    cyc();

    cfg_count  = 3'd3;
    cfg_target = 7'd2;
    pulse_start();
    chk("start_view", 32'(view), 1);
    chk("start_pc", 32'(player_count), 3);
    chk("start_scores", 32'({p1, p2, p3, p4}), 0);

    do_buzz(4'b0110);
    chk("b0110_ans", 32'(answering), 2);
    chk("b0110_tl", 32'(time_left), 50);
    pulse_ok();
    chk("ok_p2", 32'(p2), 1);
    chk("ok_view", 32'(view), 1);
    chk("ok_ans", 32'(answering), 0);

    do_buzz(4'b1000);
    chk("unused_buzz", 32'(answering), 0);
    do_buzz(4'b1001);
    chk("b1001_ans", 32'(answering), 1);
    ticks(1);
    chk("tick_tl", 32'(time_left), 49);
    buzz = 4'b0010;
    cyc();
    buzz = 4'd0;
    chk("buzz_in_answer", 32'(answering), 1);
    ticks(49);
    chk("timeout_p1", 32'(p1), 0);
    chk("timeout_ans", 32'(answering), 0);
    chk("timeout_tl", 32'(time_left), 0);

    do_buzz(4'b0010);
    ticks(50);
    chk("timeout_p2", 32'(p2), 0);

    judge_ok = 1'b1;
    cyc();
    judge_ok = 1'b0;
    chk("judge_ready", 32'(p1 + p2 + p3), 0);
    pulse_start();
    chk("start_ready_view", 32'(view), 1);

    do_buzz(4'b0100);
    judge_bad = 1'b1;
    cyc();
    judge_bad = 1'b0;
    chk("bad_p3_sat", 32'(p3), 0);
    do_buzz(4'b0100);
    pulse_ok();
    chk("ok_p3", 32'(p3), 1);

    do_buzz(4'b0100);
    judge_ok  = 1'b1;
    judge_bad = 1'b1;
    cyc();
    judge_ok  = 1'b0;
    judge_bad = 1'b0;
    chk("both_p3", 32'(p3), 1);
    chk("both_ans", 32'(answering), 3);
    ticks(2);
    judge_ok = 1'b1;
    tick_100ms = 1'b1;
    cyc();
    judge_ok = 1'b0;
    tick_100ms = 1'b0;
    chk("win_p3", 32'(p3), 2);
    chk("win_view", 32'(view), 2);
    chk("win_winner", 32'(winner), 3);
    chk("win_ans", 32'(answering), 0);

    pulse_start();
    chk("win_start_view", 32'(view), 0);
    chk("setup_p3_kept", 32'(p3), 2);
    cfg_count  = 3'd7;
    cfg_target = 7'd120;
    pulse_start();
    chk("restart_view", 32'(view), 1);
    chk("restart_scores", 32'({p1, p2, p3, p4}), 0);
    chk("restart_winner", 32'(winner), 0);
    chk("clamp_pc_hi", 32'(player_count), 4);

    do_buzz(4'b1000);
    chk("p4_buzz", 32'(answering), 4);
    pulse_ok();
    chk("p4_score", 32'(p4), 1);
    chk("tgt99_view", 32'(view), 1);

    do_buzz(4'b0001);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("async_rst");
    cyc();
    rst = 1'b1;
    cfg_count  = 3'd0;
    cfg_target = 7'd0;
    pulse_start();
    chk("clamp_pc_lo", 32'(player_count), 2);
    do_buzz(4'b0100);
    chk("clamp_unused3", 32'(answering), 0);
    do_buzz(4'b0001);
    pulse_ok();
    chk("tgt1_view", 32'(view), 2);
    chk("tgt1_winner", 32'(winner), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
